// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display source.
// State encoding, digit positions and the seven-segment table.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [2:0] POS_M1 = 3'd0;
  localparam logic [2:0] POS_M0 = 3'd1;
  localparam logic [2:0] POS_S1 = 3'd2;
  localparam logic [2:0] POS_S0 = 3'd3;
  localparam logic [2:0] POS_C1 = 3'd4;
  localparam logic [2:0] POS_C0 = 3'd5;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  localparam logic [6:0] SEG_LUT [10] = '{
    M_A | M_B | M_C | M_D | M_E | M_F,
    M_B | M_C,
    M_A | M_B | M_D | M_E | M_G,
    M_A | M_B | M_C | M_D | M_G,
    M_B | M_C | M_F | M_G,
    M_A | M_C | M_D | M_F | M_G,
    M_A | M_C | M_D | M_E | M_F | M_G,
    M_A | M_B | M_C,
    M_A | M_B | M_C | M_D | M_E | M_F | M_G,
    M_A | M_B | M_C | M_D | M_F | M_G
  };

endpackage

// File: rtl/stopwatch_segment_source_bcd_to_seg7.sv
// BCD digit to seven-segment pattern, active-high, bit0 = a.
// Non-decimal codes render blank.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    if (i_digit <= 4'd9)
      o_seg = SEG_LUT[i_digit];
  end

endmodule

// File: rtl/stopwatch_segment_source.sv
// MM:SS:CC stopwatch with per-frame snapshot and a
// one-cycle-latency segment read port.
module stopwatch_segment_source
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 25000000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       frame_start,
  input  logic       rd_en,
  input  logic [2:0] rd_pos,
  output logic [6:0] seg_out,
  output logic       rd_valid,
  output logic       running,
  output logic       wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_m1, r_m0, r_s1, r_s0, r_c1, r_c0;
  logic [3:0]    r_snap [6];
  logic [6:0]    r_seg;
  logic          r_valid;
  logic          r_wrap;
  logic          w_tick;
  logic          w_cy_c1, w_cy_s0, w_cy_s1, w_cy_m;
  logic          w_m_last;
  logic          w_roll;
  logic [3:0]    w_rd_digit;
  logic [6:0]    w_seg;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // clear outranks a coincident start_stop
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_tick   = (r_state == ST_RUN) && (r_pre == PRE_LAST);
  assign w_cy_c1  = w_tick  && (r_c0 == 4'd9);
  assign w_cy_s0  = w_cy_c1 && (r_c1 == 4'd9);
  assign w_cy_s1  = w_cy_s0 && (r_s0 == 4'd9);
  assign w_cy_m   = w_cy_s1 && (r_s1 == 4'd5);
  assign w_m_last = (r_m1 == MAX_M1) && (r_m0 == MAX_M0);
  assign w_roll   = w_cy_m && w_m_last;

  // prescaler holds through PAUSE so no fraction is lost
  always_ff @(posedge clk) begin
    if (rst || clear)
      r_pre <= '0;
    else if (r_state == ST_RUN)
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    else if (r_state == ST_IDLE)
      r_pre <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_c0 <= '0; r_c1 <= '0;
      r_s0 <= '0; r_s1 <= '0;
      r_m0 <= '0; r_m1 <= '0;
    end else begin
      if (w_tick)
        r_c0 <= (r_c0 == 4'd9) ? 4'd0 : r_c0 + 4'd1;
      if (w_cy_c1)
        r_c1 <= (r_c1 == 4'd9) ? 4'd0 : r_c1 + 4'd1;
      if (w_cy_s0)
        r_s0 <= (r_s0 == 4'd9) ? 4'd0 : r_s0 + 4'd1;
      if (w_cy_s1)
        r_s1 <= (r_s1 == 4'd5) ? 4'd0 : r_s1 + 4'd1;
      if (w_cy_m) begin
        if (w_m_last) begin
          r_m0 <= '0;
          r_m1 <= '0;
        end else if (r_m0 == 4'd9) begin
          r_m0 <= '0;
          r_m1 <= r_m1 + 4'd1;
        end else begin
          r_m0 <= r_m0 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_wrap <= 1'b0;
    else     r_wrap <= w_roll && !clear;
  end

  // copies pre-increment digits when a tick shares the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_snap[i] <= '0;
    end else if (frame_start) begin
      r_snap[POS_M1] <= r_m1;
      r_snap[POS_M0] <= r_m0;
      r_snap[POS_S1] <= r_s1;
      r_snap[POS_S0] <= r_s0;
      r_snap[POS_C1] <= r_c1;
      r_snap[POS_C0] <= r_c0;
    end
  end

  always_comb begin
    w_rd_digit = 4'hF;
    case (rd_pos)
      POS_M1:  w_rd_digit = r_snap[POS_M1];
      POS_M0:  w_rd_digit = r_snap[POS_M0];
      POS_S1:  w_rd_digit = r_snap[POS_S1];
      POS_S0:  w_rd_digit = r_snap[POS_S0];
      POS_C1:  w_rd_digit = r_snap[POS_C1];
      POS_C0:  w_rd_digit = r_snap[POS_C0];
      default: w_rd_digit = 4'hF;
    endcase
  end

  bcd_to_seg7 u_seg (
    .i_digit (w_rd_digit),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= 7'h00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_en;
      r_seg   <= rd_en ? w_seg : 7'h00;
    end
  end

  assign seg_out  = r_seg;
  assign rd_valid = r_valid;
  assign running  = (r_state == ST_RUN);
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_segment_source.sv
// Directed bench: instance A (DIV=10, MAX_MIN=59) for control and
// snapshot cases, instance B (DIV=2, MAX_MIN=1) for a fast rollover.
module tb_stopwatch_segment_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_a = 1'b0, ss_b = 1'b0, clr = 1'b0, fs = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_pos = 3'd0;
  logic [6:0] seg_a, seg_b;
  logic       val_a, val_b, run_a, run_b, wrap_a, wrap_b;

  int n_chk = 0;
  int n_pass = 0;
  int wrap_cnt_a = 0;
  int wrap_cnt_b = 0;

  always #5 clk = ~clk;

  stopwatch_segment_source #(
    .CLK_HZ(100), .TICK_HZ(10), .MAX_MIN(59)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start_stop(ss_a), .clear(clr),
    .frame_start(fs), .rd_en(rd_en), .rd_pos(rd_pos),
    .seg_out(seg_a), .rd_valid(val_a), .running(run_a),
    .wrap(wrap_a)
  );

  stopwatch_segment_source #(
    .CLK_HZ(2), .TICK_HZ(1), .MAX_MIN(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start_stop(ss_b), .clear(clr),
    .frame_start(fs), .rd_en(rd_en), .rd_pos(rd_pos),
    .seg_out(seg_b), .rd_valid(val_b), .running(run_b),
    .wrap(wrap_b)
  );

  always @(negedge clk) begin
    if (wrap_a) wrap_cnt_a++;
    if (wrap_b) wrap_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // all pulse tasks start at a falling edge and span one rising edge
  task automatic pulse_ss_a();
    ss_a = 1'b1; @(negedge clk); ss_a = 1'b0;
  endtask

  task automatic pulse_ss_b();
    ss_b = 1'b1; @(negedge clk); ss_b = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1; @(negedge clk); fs = 1'b0;
  endtask

  task automatic read_all(input bit b, input string tag,
                          input logic [3:0] m1, m0, s1, s0, c1, c0);
    logic [3:0] d [6];
    d = '{m1, m0, s1, s0, c1, c0};
    for (int i = 0; i < 6; i++) begin
      rd_en  = 1'b1;
      rd_pos = 3'(i);
      @(negedge clk);
      chk($sformatf("%s_vld%0d", tag, i), b ? val_b : val_a, 1);
      chk($sformatf("%s_seg%0d", tag, i), b ? seg_b : seg_a,
          seg_of(d[i]));
    end
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_run", run_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_vld", val_a, 0);
    chk("rst_seg", seg_a, 7'h00);
    chk("rst_run_b", run_b, 0);
    rst = 1'b0;

    pulse_fs();
    read_all(0, "zero", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_off_vld", val_a, 0);
    chk("rd_off_seg", seg_a, 7'h00);
    rd_en = 1'b1; rd_pos = 3'd6;
    @(negedge clk);
    chk("pos6_vld", val_a, 1);
    chk("pos6_seg", seg_a, 7'h00);
    rd_pos = 3'd7;
    @(negedge clk);
    chk("pos7_vld", val_a, 1);
    chk("pos7_seg", seg_a, 7'h00);
    rd_en = 1'b0;
    @(negedge clk);
    chk("rd_idle_vld", val_a, 0);

    // B: run to 01:59:98, pause, inspect, then cross the rollover
    pulse_ss_b();
    repeat (23995) @(negedge clk);
    pulse_ss_b();
    pulse_fs();
    read_all(1, "b_pre", 0, 1, 5, 9, 9, 8);
    chk("b_paused", run_b, 0);
    chk("b_wrap_none", wrap_cnt_b, 0);
    pulse_ss_b();
    repeat (3) @(negedge clk);
    chk("b_wrap_early", wrap_b, 0);
    @(negedge clk);
    chk("b_wrap_pulse", wrap_b, 1);
    pulse_fs();
    chk("b_wrap_fall", wrap_b, 0);
    read_all(1, "b_roll", 0, 0, 0, 0, 0, 0);
    chk("b_wrap_once", wrap_cnt_b, 1);
    chk("b_run_after", run_b, 1);

    // A: 250 cycles at DIV=10 is 25 centiseconds
    pulse_clr();
    pulse_ss_a();
    repeat (250) @(negedge clk);
    chk("a_run", run_a, 1);
    pulse_fs();
    read_all(0, "a25", 0, 0, 0, 0, 2, 5);

    // pause mid-count keeps the prescaler fraction
    pulse_clr();
    chk("clr_idle", run_a, 0);
    pulse_ss_a();
    repeat (373) @(negedge clk);
    pulse_ss_a();
    chk("pause_run", run_a, 0);
    repeat (100) @(negedge clk);
    pulse_ss_a();
    chk("resume_run", run_a, 1);
    repeat (5) @(negedge clk);
    pulse_fs();
    pulse_ss_a();
    read_all(0, "p37", 0, 0, 0, 0, 3, 7);
    pulse_fs();
    read_all(0, "p38", 0, 0, 0, 0, 3, 8);

    // tick on the frame_start edge captures the old value
    pulse_clr();
    pulse_ss_a();
    repeat (99) @(negedge clk);
    pulse_fs();
    pulse_ss_a();
    read_all(0, "co09", 0, 0, 0, 0, 0, 9);
    pulse_fs();
    read_all(0, "co10", 0, 0, 0, 0, 1, 0);

    // clear beats start_stop; snapshot untouched until next frame
    pulse_ss_a();
    chk("cs_run", run_a, 1);
    clr = 1'b1; ss_a = 1'b1;
    @(negedge clk);
    clr = 1'b0; ss_a = 1'b0;
    chk("cs_idle", run_a, 0);
    read_all(0, "cs_keep", 0, 0, 0, 0, 1, 0);
    pulse_fs();
    read_all(0, "cs_zero", 0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    chk("cs_stay_idle", run_a, 0);
    pulse_ss_a();
    chk("cs_restart", run_a, 1);

    // reset in the middle of a run
    repeat (30) @(negedge clk);
    rd_en = 1'b1; rd_pos = 3'd5;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    chk("mr_run", run_a, 0);
    chk("mr_vld", val_a, 0);
    chk("mr_seg", seg_a, 7'h00);
    pulse_fs();
    read_all(0, "mr_zero", 0, 0, 0, 0, 0, 0);
    chk("a_no_wrap", wrap_cnt_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_segment_source.md
Name: stopwatch_segment_source

Overview:
- Timekeeping and digit-encoding end of the stopwatch display path.
- Counts elapsed time as MM:SS:CC (minutes, seconds, centiseconds) under start/stop/clear control.
- Converts each digit to a seven-segment pattern and serves patterns by digit position to the pixel-side segment renderer.
- The displayed time is latched once per video frame, so a frame never shows a mixed time.

Parameters:
CLK_HZ, 25000000, pixel/system clock frequency in Hz
TICK_HZ, 100, count rate (centisecond); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
MAX_MIN, 59, highest minutes value before wrap

Ports:
clk  in  1  pixel/system clock
rst  in  1  synchronous, active-high reset
start_stop  in  1  one-cycle pulse; toggles run/pause
clear  in  1  one-cycle pulse; returns time to 00:00:00 and stops
frame_start  in  1  one-cycle pulse at start of each video frame; triggers snapshot
rd_en  in  1  segment read request
rd_pos  in  3  digit position 0..5, left to right (M1 M0 S1 S0 C1 C0)
seg_out  out  7  segment pattern, bit0=a … bit6=g, active-high
rd_valid  out  1  seg_out valid
running  out  1  high in RUN state
wrap  out  1  one-cycle pulse on rollover MAX_MIN:59:99 -> 00:00:00

Behaviour:
- Reset (rst=1 at clk edge):
  - State=IDLE; all time and snapshot digits 0; prescaler 0.
  - seg_out=7'h00, rd_valid=0, running=0, wrap=0.
- FSM states IDLE, RUN, PAUSE:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - Any state --clear--> IDLE with time zeroed and prescaler zeroed.
  - Simultaneous clear and start_stop: clear wins; the start_stop is dropped.
- Prescaler:
  - Counts 0..DIV-1 only in RUN. Holds its value in PAUSE (no lost fraction); 0 in IDLE.
  - Terminal count produces a tick in that same cycle; time advances on that edge.
- Time counters: BCD digits C0, C1, S0, S1, M0, M1, 4 bits each.
  - C0 wraps 9->0 and carries to C1; C1 wraps 9->0 and carries to S0.
  - S0 wraps 9->0 and carries to S1; S1 wraps 5->0 and carries to minutes.
  - Minutes count 00..MAX_MIN (BCD); carry out of minutes wraps to 0.
  - Full rollover at MAX_MIN:59:99 -> 00:00:00 pulses wrap for 1 cycle; state stays RUN.
  - No binary-to-BCD conversion is needed.
- Snapshot:
  - On frame_start, all six time digits are copied to the snapshot registers.
  - If a tick lands in the same cycle as frame_start, the pre-increment value is captured.
  - clear does not touch the snapshot; the zeroed time appears at the next frame_start.
- Read port:
  - Latency 1. With rd_en=1 at edge N, seg_out and rd_valid=1 are registered at edge N+1 from snapshot[rd_pos] (snapshot value at edge N).
  - rd_en=0: rd_valid=0 and seg_out=7'h00.
  - rd_pos 6 or 7: rd_valid=1, seg_out=7'h00 (blank).
  - Back-to-back reads every cycle are supported.
- Encoding (bit0=a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any digit value >9 encodes as 7'h00.
- Reset mid-run takes effect at that edge; no state survives.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state encoding (IDLE/RUN/PAUSE).
  - Digit position constants POS_M1..POS_C0 = 0..5.
  - Segment bit indices SEG_A..SEG_G.
  - Digit-to-segment constant table.
- One natural sub-module: bcd_to_seg7, combinational 4-bit digit -> 7-bit pattern. Instantiated once after the position mux, ahead of the output register.

Test Plan:
- Reset, frame_start, then read rd_pos 0..5 back-to-back -> rd_valid one cycle after each rd_en, seg_out=3F for all six; rd_pos=6 -> 00.
- CLK_HZ=100, TICK_HZ=10 (DIV=10): start_stop, run 250 cycles, frame_start, read -> digits 00:00:25 (positions 4, 5 = 5B, 6D); running=1.
- Same setup: pause after 37 ticks plus 4 cycles, wait 100 cycles, resume, then 6 more cycles -> exactly 38 ticks total (fraction preserved).
- Preload near 59:59:98 by running in sim; after 2 ticks -> wrap pulses once, snapshot shows 00:00:00, state RUN.
- clear and start_stop in the same cycle while in RUN -> state IDLE, running=0, time zero; the next start_stop -> RUN.
- Tick coincident with frame_start at time 00:00:09 -> snapshot reads 00:00:09; the next frame_start reads 00:00:10.
